// File: rtl/i2s_tx.sv
// Philips I2S transmitter: generates BCLK/LRCLK from the system clock and sends each
// buffered mono sample MSB-first on both channels, with a two-entry input FIFO.
module i2s_tx #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned DIV_HALF = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  output logic                sample_ready_o,
  output logic                bclk_o,
  output logic                lrclk_o,
  output logic                sdata_o,
  output logic                frame_start_o,
  output logic                underrun_o
);

  localparam int unsigned DivW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int unsigned CntW = $clog2(2 * SLOT_W);

  logic [DivW-1:0]     div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d, bit_cnt_nxt, slot_pos;
  logic                lrclk_q, lrclk_d, lr_nxt;
  logic                sdata_q, sdata_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] last_q, last_d;
  logic                frame_start_q, underrun_q;

  logic [SAMPLE_W-1:0] mem_q [2];
  logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  logic tc, fall, frame_evt, push, pop, empty;

  assign tc        = (div_q == DivW'(DIV_HALF - 1));
  assign fall      = tc && bclk_q;
  assign bit_cnt_nxt = (bit_cnt_q == CntW'(2 * SLOT_W - 1)) ? '0 : bit_cnt_q + CntW'(1);
  assign frame_evt = fall && (bit_cnt_nxt == '0);
  assign lr_nxt    = (bit_cnt_nxt >= CntW'(SLOT_W));
  assign slot_pos  = lr_nxt ? (bit_cnt_nxt - CntW'(SLOT_W)) : bit_cnt_nxt;

  assign empty          = (count_q == 2'd0);
  assign sample_ready_o = (count_q != 2'd2);
  assign push           = sample_valid_i && sample_ready_o;
  // A pop decision sees the FIFO as it was before this clock's push: no bypass.
  assign pop            = frame_evt && !empty;

  always_comb begin
    div_d     = tc ? '0 : div_q + DivW'(1);
    bclk_d    = tc ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    shift_d   = shift_q;
    last_d    = last_q;
    if (frame_evt) begin
      last_d = pop ? mem_q[rd_ptr_q] : '0;
    end
    if (fall) begin
      bit_cnt_d = bit_cnt_nxt;
      lrclk_d   = lr_nxt;
      if (slot_pos == '0) begin
        sdata_d = 1'b0;
        shift_d = last_d;
      end else if (slot_pos <= CntW'(SAMPLE_W)) begin
        sdata_d = shift_q[SAMPLE_W-1];
        shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_q         <= '0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= CntW'(2 * SLOT_W - 1);
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      shift_q       <= '0;
      last_q        <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      shift_q       <= shift_d;
      last_q        <= last_d;
      frame_start_q <= frame_evt;
      underrun_q    <= frame_evt && empty;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_i;
    end
  end

  assign bclk_o        = bclk_q;
  assign lrclk_o       = lrclk_q;
  assign sdata_o       = sdata_q;
  assign frame_start_o = frame_start_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a queue of accepted samples predicts each frame's
// content and underrun flag; scenario tasks check reset, timing and handshake behaviour.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, bclk, lrclk, sdata, frame_start, underrun;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  i2s_tx #(.SAMPLE_W(16), .SLOT_W(32), .DIV_HALF(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .sample_ready_o (sample_ready),
    .bclk_o         (bclk),
    .lrclk_o        (lrclk),
    .sdata_o        (sdata),
    .frame_start_o  (frame_start),
    .underrun_o     (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

  // Scoreboard: accepted samples in order; each frame start consumes the head.
  logic [15:0] exp_q [$];
  logic        mon_pv;
  logic [15:0] mon_ps;
  logic [15:0] cur_exp;
  logic        exp_ur;
  logic [31:0] obs_l, obs_r, lr_l, lr_r, exp_slot;
  int          cyc = 0;
  int          k;
  bit          in_frame = 0;
  bit          have_prev = 0;

  always @(posedge clk) begin
    mon_pv = sample_valid && sample_ready;
    mon_ps = sample;
    #1;
    if (!rst) begin
      exp_q.delete();
      in_frame  = 0;
      have_prev = 0;
      cyc       = 0;
    end else begin
      cyc++;
      if (frame_start) begin
        exp_ur = (exp_q.size() == 0);
        chk_cnt++;
        if (underrun !== exp_ur)
          $display("FAIL underrun_at_frame_start: got %b expected %b", underrun, exp_ur);
        else pass_cnt++;
        if (have_prev) begin
          chk_cnt++;
          if (cyc != 512) $display("FAIL frame_period: got %0d expected 512", cyc);
          else pass_cnt++;
        end
        cur_exp   = exp_ur ? 16'h0000 : exp_q.pop_front();
        have_prev = 1;
        in_frame  = 1;
        cyc       = 0;
      end
      if (mon_pv) exp_q.push_back(mon_ps);
      if (in_frame && (cyc % 8 == 4)) begin
        k = cyc / 8;
        if (k < 32) begin
          obs_l[31-k] = sdata;
          lr_l[31-k]  = lrclk;
        end else begin
          obs_r[63-k] = sdata;
          lr_r[63-k]  = lrclk;
        end
        if (k == 63) begin
          in_frame = 0;
          exp_slot = {1'b0, cur_exp, 15'h0000};
          chk_cnt++;
          if (obs_l !== exp_slot) $display("FAIL left_slot: got %h expected %h", obs_l, exp_slot);
          else pass_cnt++;
          chk_cnt++;
          if (obs_r !== exp_slot) $display("FAIL right_slot: got %h expected %h", obs_r, exp_slot);
          else pass_cnt++;
          chk_cnt++;
          if (lr_l !== 32'h0) $display("FAIL lrclk_left: got %h expected 00000000", lr_l);
          else pass_cnt++;
          chk_cnt++;
          if (lr_r !== 32'hFFFF_FFFF) $display("FAIL lrclk_right: got %h expected ffffffff", lr_r);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic wait_frame_start();
    bit seen = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (frame_start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      chk_cnt++;
      $display("FAIL frame_start_timeout: got none expected pulse within 600 clocks");
    end
  endtask

  task automatic push_sample(input logic [15:0] v);
    bit ok = 0;
    @(negedge clk);
    sample       = v;
    sample_valid = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      if (sample_ready) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    if (!ok) begin
      chk_cnt++;
      $display("FAIL push_timeout: got ready=0 expected acceptance of %h", v);
    end
  endtask

  task automatic count_to_frame_start(output int rise_at, output int fs_at);
    rise_at = 0;
    fs_at   = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bclk && rise_at == 0) rise_at = n;
      if (frame_start) begin
        fs_at = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int rise_at, fs_at;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({bclk, lrclk, sdata, frame_start, underrun, sample_ready} !== 6'b000001)
      $display("FAIL reset_outputs: got %b expected 000001",
               {bclk, lrclk, sdata, frame_start, underrun, sample_ready});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    count_to_frame_start(rise_at, fs_at);
    chk_cnt++;
    if (rise_at != 4) $display("FAIL first_bclk_rise: got %0d expected 4", rise_at);
    else pass_cnt++;
    chk_cnt++;
    if (fs_at != 8) $display("FAIL first_frame_start: got %0d expected 8", fs_at);
    else pass_cnt++;
  endtask

  task automatic test_no_input();
    int ur_cnt = 0, stray = 0, hi = 0;
    repeat (3 * 512) begin
      @(posedge clk);
      #1;
      if (underrun) ur_cnt++;
      if (underrun && !frame_start) stray++;
      if (sdata) hi++;
    end
    chk_cnt++;
    if (ur_cnt != 3) $display("FAIL idle_underrun_count: got %0d expected 3", ur_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (stray != 0) $display("FAIL underrun_without_frame_start: got %0d expected 0", stray);
    else pass_cnt++;
    chk_cnt++;
    if (hi != 0) $display("FAIL idle_sdata: got %0d high clocks expected 0", hi);
    else pass_cnt++;
  endtask

  task automatic test_single(input logic [15:0] v);
    push_sample(v);
    repeat (2) wait_frame_start();
  endtask

  task automatic test_back_to_back();
    bit ok = 0;
    logic fs_seen = 1'b0;
    wait_frame_start();
    @(negedge clk);
    sample       = 16'h0001;
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample = 16'h0002;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (sample_ready !== 1'b0) $display("FAIL ready_after_fill: got %b expected 0", sample_ready);
    else pass_cnt++;
    @(negedge clk);
    sample = 16'h0003;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      if (sample_ready) begin
        fs_seen = frame_start;
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    chk_cnt++;
    if (!ok || fs_seen !== 1'b1)
      $display("FAIL third_accept_after_frame_start: got accepted=%0d fs=%b expected 1 1",
               ok, fs_seen);
    else pass_cnt++;
    repeat (3) wait_frame_start();
  endtask

  task automatic test_push_at_frame_start();
    for (int i = 0; i < 4; i++) begin
      wait_frame_start();
      if (underrun) break;
    end
    repeat (511) @(posedge clk);
    @(negedge clk);
    sample       = 16'h1234;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({frame_start, underrun} !== 2'b11)
      $display("FAIL push_on_frame_start_underrun: got %b expected 11", {frame_start, underrun});
    else pass_cnt++;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) wait_frame_start();
  endtask

  task automatic test_reset_mid_frame();
    int rise_at, fs_at;
    push_sample(16'hFFFF);
    push_sample(16'hFFFF);
    wait_frame_start();
    repeat (100) @(posedge clk);
    #1;
    chk_cnt++;
    if ({bclk, sdata} !== 2'b11) $display("FAIL pre_reset_activity: got %b expected 11", {bclk, sdata});
    else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if ({bclk, lrclk, sdata, frame_start, underrun, sample_ready} !== 6'b000001)
      $display("FAIL mid_frame_reset_outputs: got %b expected 000001",
               {bclk, lrclk, sdata, frame_start, underrun, sample_ready});
    else pass_cnt++;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    count_to_frame_start(rise_at, fs_at);
    chk_cnt++;
    if (fs_at != 8) $display("FAIL frame_start_after_mid_reset: got %0d expected 8", fs_at);
    else pass_cnt++;
    wait_frame_start();
  endtask

  initial begin
    test_reset();
    test_no_input();
    test_single(16'hA5C3);
    test_single(16'h8000);
    test_back_to_back();
    test_push_at_frame_start();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
